// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the write-back stage: load opcodes,
// CP0 register indices and the load-kind decoder.
package wb_regfile_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    typedef enum logic [2:0] {
        LD_NONE,
        LD_B,
        LD_BU,
        LD_H,
        LD_HU,
        LD_W
    } ld_kind_e;

    function automatic ld_kind_e ld_decode(input logic [5:0] op);
        ld_kind_e k;
        k = LD_NONE;
        case (op)
            OP_LB:   k = LD_B;
            OP_LBU:  k = LD_BU;
            OP_LH:   k = LD_H;
            OP_LHU:  k = LD_HU;
            OP_LW:   k = LD_W;
            default: k = LD_NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// Extracts a byte, half or word from the data-memory word
// (little-endian) and applies sign or zero extension.
module wb_load_align
    import wb_regfile_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [31:0] do_i,
    input  logic [1:0]  off_i,
    output logic        memtoreg_o,
    output logic [31:0] data_o
);

    ld_kind_e    kind;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign kind = ld_decode(op_i);
    assign memtoreg_o = (kind != LD_NONE);

    always_comb begin
        byte_sel = do_i[7:0];
        case (off_i)
            2'd0: byte_sel = do_i[7:0];
            2'd1: byte_sel = do_i[15:8];
            2'd2: byte_sel = do_i[23:16];
            2'd3: byte_sel = do_i[31:24];
            default: byte_sel = do_i[7:0];
        endcase
    end

    assign half_sel = off_i[1] ? do_i[31:16] : do_i[15:0];

    always_comb begin
        data_o = do_i;
        case (kind)
            LD_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   data_o = {24'h0, byte_sel};
            LD_H:    data_o = {{16{half_sel[15]}}, half_sel};
            LD_HU:   data_o = {16'h0, half_sel};
            default: data_o = do_i;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: commits GPR/HI/LO/CP0 state, bypasses the
// in-flight GPR write to the read ports, counts retired instructions.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int CP0_REGS = 32,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op_wr,
    input  logic [4:0]       Rw_wr,
    input  logic [4:0]       rd_wr,
    input  logic [31:0]      Do_wr,
    input  logic [31:0]      Result_wr,
    input  logic [31:0]      Result_next_wr,
    input  logic             RegWr_wr,
    input  logic             CPR_wr,
    input  logic             Hi_wr,
    input  logic             Lo_wr,
    input  logic             Hi_Lo_wr,
    input  logic             loaduse_wr,
    input  logic             xiaoc_wr,
    input  logic [31:0]      pc_wr,
    input  logic [4:0]       ra1,
    input  logic [4:0]       ra2,
    output logic [31:0]      rd1,
    output logic [31:0]      rd2,
    output logic [31:0]      hi_q,
    output logic [31:0]      lo_q,
    input  logic [4:0]       cp0_ra,
    output logic [31:0]      cp0_rd,
    output logic [31:0]      wb_data,
    output logic             wb_we,
    output logic [CNT_W-1:0] instret
);

    logic             valid;
    logic             memtoreg;
    logic [31:0]      ld_data;

    logic [31:0]      gpr_q [32];
    logic [31:0]      hi_d, hi_r_q;
    logic [31:0]      lo_d, lo_r_q;
    logic [31:0]      status_d, status_q;
    logic [31:0]      cause_d, cause_q;
    logic [31:0]      epc_d, epc_q;
    logic [CNT_W-1:0] instret_d, instret_q;

    assign valid = !loaduse_wr && !xiaoc_wr;

    wb_load_align u_align (
        .op_i       (op_wr),
        .do_i       (Do_wr),
        .off_i      (Result_wr[1:0]),
        .memtoreg_o (memtoreg),
        .data_o     (ld_data)
    );

    assign wb_data = memtoreg ? ld_data : Result_wr;
    assign wb_we   = valid && RegWr_wr && (Rw_wr != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
        end else if (wb_we) begin
            gpr_q[Rw_wr] <= wb_data;
        end
    end

    // Same-cycle write-then-read: the committing value wins.
    always_comb begin
        rd1 = gpr_q[ra1];
        if (ra1 == 5'd0) rd1 = '0;
        else if (wb_we && ra1 == Rw_wr) rd1 = wb_data;
    end

    always_comb begin
        rd2 = gpr_q[ra2];
        if (ra2 == 5'd0) rd2 = '0;
        else if (wb_we && ra2 == Rw_wr) rd2 = wb_data;
    end

    always_comb begin
        hi_d = hi_r_q;
        lo_d = lo_r_q;
        if (valid) begin
            if (Hi_Lo_wr) begin
                hi_d = Result_next_wr;
                lo_d = Result_wr;
            end else begin
                if (Hi_wr) hi_d = Result_wr;
                if (Lo_wr) lo_d = Result_wr;
            end
        end
    end

    always_comb begin
        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        if (valid && CPR_wr) begin
            case (rd_wr)
                CP0_STATUS: status_d = Result_wr;
                CP0_CAUSE:  cause_d  = Result_wr;
                CP0_EPC:    epc_d    = Result_wr;
                default:    ;
            endcase
        end
    end

    // pc_wr == 0 is the empty pipeline after reset, not a retirement.
    always_comb begin
        instret_d = instret_q;
        if (valid && pc_wr != 32'd0) instret_d = instret_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r_q    <= '0;
            lo_r_q    <= '0;
            status_q  <= '0;
            cause_q   <= '0;
            epc_q     <= '0;
            instret_q <= '0;
        end else begin
            hi_r_q    <= hi_d;
            lo_r_q    <= lo_d;
            status_q  <= status_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            instret_q <= instret_d;
        end
    end

    assign hi_q    = hi_r_q;
    assign lo_q    = lo_r_q;
    assign instret = instret_q;

    always_comb begin
        cp0_rd = '0;
        if (int'(cp0_ra) < CP0_REGS) begin
            case (cp0_ra)
                CP0_STATUS: cp0_rd = status_q;
                CP0_CAUSE:  cp0_rd = cause_q;
                CP0_EPC:    cp0_rd = epc_q;
                default:    cp0_rd = '0;
            endcase
        end
    end

endmodule
